// File: rtl/stack_tn.sv
// LIFO with registered top/next-of-stack, depth tracking and sticky error flags.
// WRAP selects circular (ops always execute) or saturating (illegal ops suppressed).
module stack_tn #(
  parameter int WIDTH     = 16,
  parameter int DEPTHLOG2 = 3,
  parameter int WRAP      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clr_err,
  input  logic [DEPTHLOG2-1:0] pick_idx,
  output logic [WIDTH-1:0]     tos,
  output logic [WIDTH-1:0]     nos,
  output logic [WIDTH-1:0]     pick_data,
  output logic [DEPTHLOG2:0]   depth,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int N = 1 << DEPTHLOG2;
  localparam logic [DEPTHLOG2:0] DEPTH_MAX = {1'b1, {DEPTHLOG2{1'b0}}};
  localparam bit WRAP_MODE = (WRAP != 0);

  typedef logic [DEPTHLOG2-1:0] ptr_t;

  logic [WIDTH-1:0] mem [0:N-1];

  ptr_t               ptr_reg;
  logic [DEPTHLOG2:0] depth_reg;
  logic [WIDTH-1:0]   tos_reg;
  logic [WIDTH-1:0]   nos_reg;
  logic [WIDTH-1:0]   pick_reg;
  logic               overflow_reg;
  logic               underflow_reg;

  logic is_full, is_empty;
  logic do_push, do_pop, do_repl;
  logic ovf_set, unf_set, exec;
  logic wr_en;
  ptr_t ptr_m1, ptr_m3, wr_addr, pick_addr;

  assign is_full  = (depth_reg == DEPTH_MAX);
  assign is_empty = (depth_reg == '0);

  assign do_push = push & ~pop;
  assign do_pop  = pop & ~push;
  assign do_repl = push & pop;

  // Replace at full is legal; replace at empty counts as an underflow.
  assign ovf_set = do_push & is_full;
  assign unf_set = pop & is_empty;
  assign exec    = WRAP_MODE || !(ovf_set || unf_set);

  assign ptr_m1    = ptr_reg - ptr_t'(1);
  assign ptr_m3    = ptr_reg - ptr_t'(3);
  assign pick_addr = ptr_m1 - pick_idx;
  assign wr_addr   = do_repl ? ptr_m1 : ptr_reg;
  assign wr_en     = !reset && exec && push;

  // Storage is never reset; stale contents stay visible through pick.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg       <= '0;
      depth_reg     <= '0;
      tos_reg       <= '0;
      nos_reg       <= '0;
      pick_reg      <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (exec) begin
        if (do_push) begin
          ptr_reg <= ptr_reg + ptr_t'(1);
          tos_reg <= in;
          nos_reg <= tos_reg;
          if (!is_full) begin
            depth_reg <= depth_reg + 1'b1;
          end
        end else if (do_pop) begin
          ptr_reg <= ptr_m1;
          tos_reg <= nos_reg;
          nos_reg <= mem[ptr_m3];
          if (!is_empty) begin
            depth_reg <= depth_reg - 1'b1;
          end
        end else if (do_repl) begin
          tos_reg <= in;
        end
      end

      // Top two entries come from the registers, which may be newer than mem.
      if (pick_idx == ptr_t'(0)) begin
        pick_reg <= tos_reg;
      end else if (pick_idx == ptr_t'(1)) begin
        pick_reg <= nos_reg;
      end else begin
        pick_reg <= mem[pick_addr];
      end

      if (ovf_set) begin
        overflow_reg <= 1'b1;
      end else if (clr_err) begin
        overflow_reg <= 1'b0;
      end

      if (unf_set) begin
        underflow_reg <= 1'b1;
      end else if (clr_err) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  assign tos       = tos_reg;
  assign nos       = nos_reg;
  assign pick_data = pick_reg;
  assign depth     = depth_reg;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
endmodule

// File: tb/tb_stack_tn.sv
// Scoreboard bench for stack_tn: three instances (default, saturating 4-deep,
// circular 4-deep) share one stimulus stream; each expectation names its instance.
module tb_stack_tn;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, push, pop, clr_err;
  logic [15:0] din;
  logic [2:0]  pick_idx;

  logic [15:0] tos0, nos0, pick0, tos1, nos1, pick1, tos2, nos2, pick2;
  logic [3:0]  depth0;
  logic [2:0]  depth1, depth2;
  logic        empty0, full0, ovf0, unf0;
  logic        empty1, full1, ovf1, unf1;
  logic        empty2, full2, ovf2, unf2;

  stack_tn #(.WIDTH(16), .DEPTHLOG2(3), .WRAP(1)) u_def (
    .clk(clk), .reset(reset), .in(din), .push(push), .pop(pop), .clr_err(clr_err),
    .pick_idx(pick_idx), .tos(tos0), .nos(nos0), .pick_data(pick0), .depth(depth0),
    .empty(empty0), .full(full0), .overflow(ovf0), .underflow(unf0));

  stack_tn #(.WIDTH(16), .DEPTHLOG2(2), .WRAP(0)) u_sat (
    .clk(clk), .reset(reset), .in(din), .push(push), .pop(pop), .clr_err(clr_err),
    .pick_idx(pick_idx[1:0]), .tos(tos1), .nos(nos1), .pick_data(pick1), .depth(depth1),
    .empty(empty1), .full(full1), .overflow(ovf1), .underflow(unf1));

  stack_tn #(.WIDTH(16), .DEPTHLOG2(2), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .in(din), .push(push), .pop(pop), .clr_err(clr_err),
    .pick_idx(pick_idx[1:0]), .tos(tos2), .nos(nos2), .pick_data(pick2), .depth(depth2),
    .empty(empty2), .full(full2), .overflow(ovf2), .underflow(unf2));

  localparam int MT = 1, MN = 2, MP = 4, MD = 8, ME = 16, MF = 32;

  typedef struct {
    int          due;
    int          d;
    string       nm;
    int          m;
    logic [15:0] t, n, pk;
    int          dp;
    bit          e, f, ov, un;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    end
  endtask

  // Monitor: every settled cycle, compare whatever expectations are due.
  logic [15:0] a_t, a_n, a_pk;
  logic [31:0] a_dp;
  logic        a_e, a_f, a_ov, a_un;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      cur = q.pop_front();
      case (cur.d)
        0: begin a_t = tos0; a_n = nos0; a_pk = pick0; a_dp = 32'(depth0);
                 a_e = empty0; a_f = full0; a_ov = ovf0; a_un = unf0; end
        1: begin a_t = tos1; a_n = nos1; a_pk = pick1; a_dp = 32'(depth1);
                 a_e = empty1; a_f = full1; a_ov = ovf1; a_un = unf1; end
        default: begin a_t = tos2; a_n = nos2; a_pk = pick2; a_dp = 32'(depth2);
                 a_e = empty2; a_f = full2; a_ov = ovf2; a_un = unf2; end
      endcase
      if ((cur.m & MT) != 0) cmp(cur.nm, "tos", 32'(a_t), 32'(cur.t));
      if ((cur.m & MN) != 0) cmp(cur.nm, "nos", 32'(a_n), 32'(cur.n));
      if ((cur.m & MP) != 0) cmp(cur.nm, "pick", 32'(a_pk), 32'(cur.pk));
      if ((cur.m & MD) != 0) cmp(cur.nm, "depth", a_dp, cur.dp);
      if ((cur.m & ME) != 0) cmp(cur.nm, "empty_full", {30'd0, a_e, a_f}, {30'd0, cur.e, cur.f});
      if ((cur.m & MF) != 0) cmp(cur.nm, "ovf_unf", {30'd0, a_ov, a_un}, {30'd0, cur.ov, cur.un});
      $display("check %s inst=%0d tos=%0h nos=%0h pick=%0h depth=%0d e=%0b f=%0b ovf=%0b unf=%0b",
               cur.nm, cur.d, a_t, a_n, a_pk, a_dp, a_e, a_f, a_ov, a_un);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit p, input bit pp, input logic [15:0] d, input bit c,
                    input logic [2:0] k, input bit r);
    reset = r; push = p; pop = pp; din = d; clr_err = c; pick_idx = k;
    tick();
  endtask

  task automatic expect_(input int d, input string nm, input int m,
                         input logic [15:0] t, input logic [15:0] n, input logic [15:0] pk,
                         input int dp, input bit e, input bit f, input bit ov, input bit un);
    exp_t x;
    x.due = cyc; x.d = d; x.nm = nm; x.m = m;
    x.t = t; x.n = n; x.pk = pk; x.dp = dp;
    x.e = e; x.f = f; x.ov = ov; x.un = un;
    q.push_back(x);
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0; clr_err = 1'b0; pick_idx = '0;
    tick(); tick();

    // Reset state on every instance
    op(0, 0, 16'h0, 0, 3'd0, 1);
    for (int i = 0; i < 3; i++)
      expect_(i, "reset", MT|MN|MP|MD|ME|MF, 16'h0, 16'h0, 16'h0, 0, 1, 0, 0, 0);

    // Push / pop / replace on the default instance
    op(1, 0, 16'h1111, 0, 3'd0, 0);
    op(1, 0, 16'h2222, 0, 3'd0, 0);
    op(1, 0, 16'h3333, 0, 3'd0, 0);
    expect_(0, "push3", MT|MN|MD|ME, 16'h3333, 16'h2222, 0, 3, 0, 0, 0, 0);
    op(0, 1, 16'h0, 0, 3'd0, 0);
    expect_(0, "pop1", MT|MN|MD, 16'h2222, 16'h1111, 0, 2, 0, 0, 0, 0);
    op(1, 1, 16'hBEEF, 0, 3'd0, 0);
    expect_(0, "replace", MT|MN|MD|MF, 16'hBEEF, 16'h1111, 0, 2, 0, 0, 0, 0);
    op(0, 1, 16'h0, 0, 3'd0, 0);
    expect_(0, "pop_d1", MT|MD, 16'h1111, 0, 0, 1, 0, 0, 0, 0);
    op(0, 1, 16'h0, 0, 3'd0, 0);
    expect_(0, "pop_d0", MD|ME|MF, 0, 0, 0, 0, 1, 0, 0, 0);

    // Saturating 4-deep: overflow suppressed, then drain and underflow
    op(0, 0, 16'h0, 0, 3'd0, 1);
    for (int v = 1; v <= 4; v++) op(1, 0, 16'(v), 0, 3'd0, 0);
    expect_(1, "sat_full", MT|MN|MD|ME|MF, 16'd4, 16'd3, 0, 4, 0, 1, 0, 0);
    op(1, 0, 16'd5, 0, 3'd0, 0);
    expect_(1, "sat_ovf", MT|MN|MD|ME|MF, 16'd4, 16'd3, 0, 4, 0, 1, 1, 0);
    op(0, 1, 16'h0, 0, 3'd0, 0);
    expect_(1, "sat_pop1", MT|MN|MD, 16'd3, 16'd2, 0, 3, 0, 0, 0, 0);
    op(0, 1, 16'h0, 0, 3'd0, 0);
    expect_(1, "sat_pop2", MT|MN|MD, 16'd2, 16'd1, 0, 2, 0, 0, 0, 0);
    op(0, 1, 16'h0, 0, 3'd0, 0);
    expect_(1, "sat_pop3", MT|MD, 16'd1, 0, 0, 1, 0, 0, 0, 0);
    op(0, 1, 16'h0, 0, 3'd0, 0);
    expect_(1, "sat_pop4", MT|MN|MD|ME|MF, 16'd4, 16'd3, 0, 0, 1, 0, 1, 0);
    op(0, 1, 16'h0, 0, 3'd0, 0);
    expect_(1, "sat_unf", MT|MN|MD|ME|MF, 16'd4, 16'd3, 0, 0, 1, 0, 1, 1);

    // Circular 4-deep: push-at-full overwrites oldest, clr_err, set wins
    op(0, 0, 16'h0, 0, 3'd0, 1);
    for (int v = 1; v <= 5; v++) op(1, 0, 16'(v), 0, 3'd0, 0);
    expect_(2, "wrap_ovf", MT|MN|MD|ME|MF, 16'd5, 16'd4, 0, 4, 0, 1, 1, 0);
    op(0, 1, 16'h0, 0, 3'd0, 0);
    expect_(2, "wrap_pop", MT|MN|MD, 16'd4, 16'd3, 0, 3, 0, 0, 0, 0);
    op(0, 0, 16'h0, 1, 3'd0, 0);
    expect_(2, "clr_err", MD|MF, 0, 0, 0, 3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) op(0, 1, 16'h0, 0, 3'd0, 0);
    expect_(2, "wrap_drain", MT|MN|MD|ME|MF, 16'd5, 16'd4, 0, 0, 1, 0, 0, 0);
    op(0, 1, 16'h0, 1, 3'd0, 0);
    expect_(2, "set_wins", MT|MN|MD|MF, 16'd4, 16'd3, 0, 0, 1, 0, 0, 1);

    // Pick sweep on the default instance
    op(0, 0, 16'h0, 0, 3'd0, 1);
    for (int v = 0; v < 4; v++) op(1, 0, 16'hA0 + 16'(v), 0, 3'd0, 0);
    for (int k = 0; k < 4; k++) begin
      op(0, 0, 16'h0, 0, 3'(k), 0);
      expect_(0, $sformatf("pick%0d", k), MP|MD, 0, 0, 16'hA3 - 16'(k), 4, 0, 0, 0, 0);
    end

    // Reset coinciding with a push at depth 3
    op(0, 1, 16'h0, 0, 3'd0, 0);
    expect_(0, "pre_reset", MT|MD, 16'hA2, 0, 0, 3, 0, 0, 0, 0);
    op(1, 0, 16'h55, 0, 3'd0, 1);
    expect_(0, "reset_wins", MT|MN|MP|MD|ME|MF, 16'h0, 16'h0, 16'h0, 0, 1, 0, 0, 0);
    op(1, 0, 16'h7, 0, 3'd0, 0);
    expect_(0, "post_reset", MT|MN|MD|ME, 16'h7, 16'h0, 0, 1, 0, 0, 0, 0);

    op(0, 0, 16'h0, 0, 3'd0, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0 pending", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
